seq_detect_fsm: RTL and testbench
=================================

// Module: seq_detect_fsm
// PURPOSE
// - Parametrised successor of the 16-bit simple FSM.
// - Scans a Width-bit input word stream for a programmable sequence of Depth words.
// - Flags each detection and keeps a saturating match count.
// - Sits directly behind the stimulus/checker interface, so it is driven and checked by
//   file-based vector benches (1 line per clock).
// PARAMETERS
// - Width     16  bits per input/output word
// - Depth     4   pattern length in words, >=1
// - CntWidth  8   match counter width
// - Overlap   1   1: overlapping detections allowed; 0: restart empty after a match
// PORTS
// - clk_i       in   1                 clock, rising edge
// - rst_ni      in   1                 reset, synchronous, active-low
// - cfg_we_i    in   1                 pattern register write enable
// - cfg_addr_i  in   $clog2(Depth)>=1  pattern index to write
// - cfg_data_i  in   Width             pattern word
// - valid_i     in   1                 in_i carries a word this cycle
// - in_i        in   Width             input word
// - out_o       out  Width             registered copy of last accepted in_i
// - match_o     out  1                 1-cycle pulse: sequence completed
// - count_o     out  CntWidth          saturating number of matches
// - busy_o      out  1                 prefix index != 0 (partial match in progress)
// BEHAVIOUR
// - Reset (rst_ni=0 at a posedge):
//   - pattern regs, out_o, count_o all zero; match_o=0; busy_o=0.
//   - Prefix index idx=0; FSM in IDLE.
// - FSM states:
//   - IDLE (idx=0).
//   - TRACK (0<idx<Depth); idx = number of pattern words matched so far.
//   - HIT is not a state: match_o is registered from the completing transition.
// - Accepted word (valid_i=1, cfg_we_i=0), let w=in_i, p[k]=pattern word k:
//   - w==p[idx] and idx<Depth-1 -> idx+1.
//   - w==p[Depth-1] and idx==Depth-1 -> match_o=1 next cycle; count_o+=1
//     (saturates at 2^CntWidth-1, no wrap).
//     - Next idx: Overlap=0 -> 0.
//     - Overlap=1 -> (w==p[0] ? 1 : 0).
//   - Mismatch -> idx = (w==p[0] ? 1 : 0). Simple restart, no KMP fallback.
//   - Depth=1: every word equal to p[0] is a match; idx stays 0.
// - valid_i=0: idx, out_o and count_o hold; match_o=0.
// - Output timing:
//   - out_o updates the cycle after acceptance (latency 1).
//   - match_o and count_o update in the same cycle as out_o.
// - Config write (cfg_we_i=1):
//   - p[cfg_addr_i]<=cfg_data_i; idx<=0; count_o holds.
//   - Concurrent valid_i word is dropped: no compare, out_o holds, match_o=0.
//   - cfg_addr_i>=Depth: write ignored, but idx still cleared.
// - Reset mid-sequence: partial match lost; pattern must be re-programmed.
// - count_o is cleared only by reset.
// CONFIGURATION
// - Macro SEQ_DETECT_MASK_EN:
//   - Defined: adds port cfg_mask_i (in, Width), written with cfg_data_i into a per-word
//     mask register (reset value all-ones).
//   - Compare becomes ((w ^ p[k]) & m[k]) == 0. A mask bit of 0 is don't-care.
//   - Undefined: no port, no mask registers, exact equality compare.
// STRUCTURE
// - Package seq_detect_pkg:
//   - state_e {IDLE, TRACK}.
//   - function word_eq(w, p, m) shared by RTL and bench model.
//   - Default localparams for Width/Depth/CntWidth.
// - One sub-module: sat_counter (parametrised CntWidth, inc_i, sync clear, saturating),
//   used for count_o.
// - Pattern/mask storage is a flop array in the top; no memory macro.
// TESTING (Width=16, Depth=3, p={16'h00A1,16'h00B2,16'h00C3}, Overlap=1 unless noted)
// - Basic: A1,B2,C3 on 3 valid cycles -> match_o=1 the cycle after C3; count_o=1; out_o=00C3.
// - Restart: A1,A1,B2,C3 -> single match after C3 (second A1 restarts to idx=1); count_o=1.
// - Overlap:
//   - p={A1,B2,A1}, stream A1,B2,A1,B2,A1 -> Overlap=1: 2 matches; Overlap=0: 1 match.
// - Gaps and config:
//   - valid_i low between A1 and B2 -> still matches.
//   - cfg write after A1,B2 -> idx=0; C3 gives no match; concurrent word dropped.
// - Saturation and reset:
//   - CntWidth=2, 5 matches -> count_o stays 3.
//   - rst_ni=0 for 1 cycle mid-sequence -> all outputs 0 next cycle.
// - Mask (SEQ_DETECT_MASK_EN): m[0]=16'hFF0F, input 00F1 matches p[0]=00A1.

Source files
------------

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Purpose  : Shared types, default sizes and the word-compare helper for the
//            sequence detector (RTL and reference model use the same compare).
// Contents : state_e      - FSM state encoding (IDLE, TRACK)
//            DEF_*        - default parameter values
//            WORD_MAX     - widest word the compare helper accepts
//            idx_w()      - width of a pattern index for a given depth
//            word_eq()    - masked equality, mask bit 0 = don't-care
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_CNT_WIDTH = 8;

  // Words are zero-extended to this width before comparison, so Width must
  // not exceed it.
  localparam int WORD_MAX = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // A depth of one still needs a one-bit index / address.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic word_eq(input logic [WORD_MAX-1:0] w,
                                   input logic [WORD_MAX-1:0] p,
                                   input logic [WORD_MAX-1:0] m);
    return (((w ^ p) & m) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_fsm_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at its all-ones value instead of wrapping.
// Ports    : clk_i    in  1         clock, rising edge
//            rst_ni   in  1         synchronous active-low reset
//            clr_i    in  1         synchronous clear
//            inc_i    in  1         increment request
//            count_o  out CntWidth  current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] count_o
);

  logic [CntWidth-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != '1)) begin
      r_count <= r_count + CntWidth'(1);
    end
  end

  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_fsm
// Purpose  : Scans a stream of Width-bit words for a programmable sequence of
//            Depth words; pulses match_o on each detection and keeps a
//            saturating match count.
// Ports    : clk_i       in  1         clock, rising edge
//            rst_ni      in  1         synchronous active-low reset
//            cfg_we_i    in  1         pattern register write enable
//            cfg_addr_i  in  idx_w     pattern index to write
//            cfg_data_i  in  Width     pattern word
//            cfg_mask_i  in  Width     mask word (SEQ_DETECT_MASK_EN only)
//            valid_i     in  1         in_i carries a word this cycle
//            in_i        in  Width     input word
//            out_o       out Width     registered copy of last accepted word
//            match_o     out 1         one-cycle detection pulse
//            count_o     out CntWidth  saturating match count
//            busy_o      out 1         partial match in progress
// Config   : SEQ_DETECT_MASK_EN - adds per-word compare masks (reset all-ones)
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int Width    = DEF_WIDTH,
  parameter int Depth    = DEF_DEPTH,
  parameter int CntWidth = DEF_CNT_WIDTH,
  parameter bit Overlap  = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_we_i,
  input  logic [idx_w(Depth)-1:0]   cfg_addr_i,
  input  logic [Width-1:0]          cfg_data_i,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [Width-1:0]          cfg_mask_i,
`endif
  input  logic                      valid_i,
  input  logic [Width-1:0]          in_i,
  output logic [Width-1:0]          out_o,
  output logic                      match_o,
  output logic [CntWidth-1:0]       count_o,
  output logic                      busy_o
);

  localparam int                c_IDX_W = idx_w(Depth);
  localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(Depth - 1);
  // Restarting at index 1 only makes sense when there is a second word.
  localparam bit c_CAN_RESTART = (Depth > 1);

  // --------------------------------------------------------------------------
  // Pattern (and optional mask) storage
  // --------------------------------------------------------------------------
  logic [Width-1:0] r_pat [Depth];
`ifdef SEQ_DETECT_MASK_EN
  logic [Width-1:0] r_mask [Depth];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) begin
        r_pat[k]  <= '0;
`ifdef SEQ_DETECT_MASK_EN
        r_mask[k] <= '1;
`endif
      end
    end else if (cfg_we_i && (32'(cfg_addr_i) < Depth)) begin
      r_pat[cfg_addr_i]  <= cfg_data_i;
`ifdef SEQ_DETECT_MASK_EN
      r_mask[cfg_addr_i] <= cfg_mask_i;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Compare the incoming word against the expected word and the first word
  // --------------------------------------------------------------------------
  logic [c_IDX_W-1:0]  r_idx;
  state_e              r_state;
  logic [Width-1:0]    r_out;
  logic                r_match;

  logic [WORD_MAX-1:0] w_in_x;
  logic [WORD_MAX-1:0] w_pat_cur_x;
  logic [WORD_MAX-1:0] w_pat_first_x;
  logic [WORD_MAX-1:0] w_msk_cur_x;
  logic [WORD_MAX-1:0] w_msk_first_x;
  logic                w_hit_cur;
  logic                w_hit_first;
  logic                w_complete;
  logic [c_IDX_W-1:0]  w_idx_nxt;

  always_comb begin
    w_in_x        = '0;
    w_pat_cur_x   = '0;
    w_pat_first_x = '0;
    w_in_x[Width-1:0]        = in_i;
    w_pat_cur_x[Width-1:0]   = r_pat[r_idx];
    w_pat_first_x[Width-1:0] = r_pat[0];
`ifdef SEQ_DETECT_MASK_EN
    w_msk_cur_x   = '0;
    w_msk_first_x = '0;
    w_msk_cur_x[Width-1:0]   = r_mask[r_idx];
    w_msk_first_x[Width-1:0] = r_mask[0];
`else
    w_msk_cur_x   = '1;
    w_msk_first_x = '1;
`endif
  end

  assign w_hit_cur   = word_eq(w_in_x, w_pat_cur_x, w_msk_cur_x);
  assign w_hit_first = word_eq(w_in_x, w_pat_first_x, w_msk_first_x);
  assign w_complete  = (r_idx == c_LAST) && w_hit_cur;

  // Next prefix index for an accepted word. A mismatch falls back only to
  // "does this word start a new sequence", never to a longer border.
  always_comb begin
    w_idx_nxt = '0;
    if (w_complete) begin
      if (Overlap && c_CAN_RESTART && w_hit_first) begin
        w_idx_nxt = c_ONE;
      end
    end else if (w_hit_cur) begin
      w_idx_nxt = r_idx + c_ONE;
    end else if (c_CAN_RESTART && w_hit_first) begin
      w_idx_nxt = c_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_out   <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (cfg_we_i) begin
        // A pattern change invalidates any partial match; the word
        // presented alongside the write is dropped.
        r_state <= IDLE;
        r_idx   <= '0;
      end else if (valid_i) begin
        r_out   <= in_i;
        r_match <= w_complete;
        r_idx   <= w_idx_nxt;
        r_state <= (w_idx_nxt != '0) ? TRACK : IDLE;
      end
    end
  end

  sat_counter #(
    .CntWidth (CntWidth)
  ) u_sat_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .inc_i   (valid_i && !cfg_we_i && w_complete),
    .count_o (count_o)
  );

  assign out_o   = r_out;
  assign match_o = r_match;
  assign busy_o  = (r_state == TRACK);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_fsm
// Purpose  : Self-checking bench. Three detector instances share one stimulus
//            stream: Overlap=1, Overlap=0, and Overlap=1 with a 2-bit count.
//            A behavioural model tracks the expected outputs of each.
// Config   : SEQ_DETECT_MASK_EN - also drives cfg_mask_i and checks masking
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_fsm;
  import seq_detect_pkg::*;

  localparam int W  = 16;
  localparam int D  = 3;
  localparam int AW = idx_w(D);
  localparam int NM = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [W-1:0]  data;
  logic [W-1:0]  mask;
  logic          valid;
  logic [W-1:0]  din;

  logic [W-1:0]  out_a, out_b, out_c;
  logic          m_a, m_b, m_c;
  logic          b_a, b_b, b_c;
  logic [7:0]    cnt_a, cnt_b;
  logic [1:0]    cnt_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(.Width(W), .Depth(D), .CntWidth(8), .Overlap(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_data_i(data),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask_i(mask),
`endif
    .valid_i(valid), .in_i(din), .out_o(out_a), .match_o(m_a), .count_o(cnt_a), .busy_o(b_a));

  seq_detect_fsm #(.Width(W), .Depth(D), .CntWidth(8), .Overlap(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_data_i(data),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask_i(mask),
`endif
    .valid_i(valid), .in_i(din), .out_o(out_b), .match_o(m_b), .count_o(cnt_b), .busy_o(b_b));

  seq_detect_fsm #(.Width(W), .Depth(D), .CntWidth(2), .Overlap(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_data_i(data),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask_i(mask),
`endif
    .valid_i(valid), .in_i(din), .out_o(out_c), .match_o(m_c), .count_o(cnt_c), .busy_o(b_c));

  // --------------------------------------------------------------------------
  // Reference model: matched-prefix length per instance, spec rules directly
  // --------------------------------------------------------------------------
  int           mdl_len   [NM];
  int           mdl_cnt   [NM];
  logic         mdl_match [NM];
  logic [W-1:0] mdl_out;
  logic [W-1:0] mdl_pat [D];
  logic [W-1:0] mdl_msk [D];
  int           mdl_ovl   [NM] = '{1, 0, 1};
  int           mdl_max   [NM] = '{255, 255, 3};

  function automatic logic mdl_eq(input logic [W-1:0] w, input int k);
    logic [WORD_MAX-1:0] mm;
`ifdef SEQ_DETECT_MASK_EN
    mm = WORD_MAX'(mdl_msk[k]);
`else
    mm = '1;
`endif
    return word_eq(WORD_MAX'(w), WORD_MAX'(mdl_pat[k]), mm);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int k = 0; k < D; k++) begin
        mdl_pat[k] = '0;
        mdl_msk[k] = '1;
      end
      for (int i = 0; i < NM; i++) begin
        mdl_len[i]   = 0;
        mdl_cnt[i]   = 0;
        mdl_match[i] = 1'b0;
      end
      mdl_out = '0;
      return;
    end
    for (int i = 0; i < NM; i++) mdl_match[i] = 1'b0;
    if (we) begin
      if (int'(addr) < D) begin
        mdl_pat[addr] = data;
        mdl_msk[addr] = mask;
      end
      for (int i = 0; i < NM; i++) mdl_len[i] = 0;
    end else if (valid) begin
      mdl_out = din;
      for (int i = 0; i < NM; i++) begin
        if (mdl_len[i] == D - 1 && mdl_eq(din, D - 1)) begin
          mdl_match[i] = 1'b1;
          if (mdl_cnt[i] < mdl_max[i]) mdl_cnt[i] = mdl_cnt[i] + 1;
          mdl_len[i] = (mdl_ovl[i] != 0 && mdl_eq(din, 0)) ? 1 : 0;
        end else if (mdl_eq(din, mdl_len[i])) begin
          mdl_len[i] = mdl_len[i] + 1;
        end else begin
          mdl_len[i] = mdl_eq(din, 0) ? 1 : 0;
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_a",   32'(out_a), 32'(mdl_out));
    chk("out_b",   32'(out_b), 32'(mdl_out));
    chk("out_c",   32'(out_c), 32'(mdl_out));
    chk("match_a", 32'(m_a),   32'(mdl_match[0]));
    chk("match_b", 32'(m_b),   32'(mdl_match[1]));
    chk("match_c", 32'(m_c),   32'(mdl_match[2]));
    chk("count_a", 32'(cnt_a), 32'(mdl_cnt[0]));
    chk("count_b", 32'(cnt_b), 32'(mdl_cnt[1]));
    chk("count_c", 32'(cnt_c), 32'(mdl_cnt[2]));
    chk("busy_a",  32'(b_a),   32'(mdl_len[0] != 0));
    chk("busy_b",  32'(b_b),   32'(mdl_len[1] != 0));
    chk("busy_c",  32'(b_c),   32'(mdl_len[2] != 0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic word(input logic [W-1:0] w);
    we = 1'b0; valid = 1'b1; din = w;
    cycle();
  endtask

  task automatic idle();
    we = 1'b0; valid = 1'b0; din = $urandom_range(0, 16'hFFFF);
    cycle();
  endtask

  task automatic cfg(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m,
                     input logic v, input logic [W-1:0] w);
    we = 1'b1; addr = a; data = d; mask = m; valid = v; din = w;
    cycle();
    we = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_word();
    case ($urandom_range(0, 4))
      0:       return 16'h00A1;
      1:       return 16'h00B2;
      2:       return 16'h00C3;
      3:       return 16'h00F1;
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; data = '0; mask = '1; valid = 1'b0; din = '0;
    cycle();
    cycle();
    chk("reset_out",   32'(out_a), 32'h0);
    chk("reset_count", 32'(cnt_a), 32'h0);
    chk("reset_busy",  32'(b_a),   32'h0);
    rst_n = 1'b1;

    cfg(2'd0, 16'h00A1, 16'hFFFF, 1'b0, 16'h0);
    cfg(2'd1, 16'h00B2, 16'hFFFF, 1'b0, 16'h0);
    cfg(2'd2, 16'h00C3, 16'hFFFF, 1'b0, 16'h0);

    // Basic detection
    word(16'h00A1); word(16'h00B2); word(16'h00C3);
    chk("basic_match", 32'(m_a),   32'h1);
    chk("basic_count", 32'(cnt_a), 32'h1);
    chk("basic_out",   32'(out_a), 32'h00C3);
    idle();

    // Repeated first word restarts at index 1
    word(16'h00A1); word(16'h00A1); word(16'h00B2);
    chk("restart_busy", 32'(b_a), 32'h1);
    word(16'h00C3);
    chk("restart_match", 32'(m_a),   32'h1);
    chk("restart_count", 32'(cnt_a), 32'h2);

    // Gap in valid_i does not break the sequence
    word(16'h00A1); idle(); word(16'h00B2); idle(); word(16'h00C3);
    chk("gap_count", 32'(cnt_a), 32'h3);

    // Config write mid-sequence clears progress and drops the concurrent word
    word(16'h00A1); word(16'h00B2);
    cfg(2'd2, 16'h00C3, 16'hFFFF, 1'b1, 16'h00C3);
    chk("cfg_busy", 32'(b_a),   32'h0);
    chk("cfg_out",  32'(out_a), 32'h00B2);
    word(16'h00C3);
    chk("cfg_nomatch", 32'(m_a),   32'h0);
    chk("cfg_count",   32'(cnt_a), 32'h3);

    // Out-of-range address: pattern unchanged, progress still cleared
    word(16'h00A1);
    cfg(2'd3, 16'h1234, 16'hFFFF, 1'b0, 16'h0);
    chk("oor_busy", 32'(b_a), 32'h0);

    // Overlap: pattern A1,B2,A1 and stream A1,B2,A1,B2,A1
    cfg(2'd2, 16'h00A1, 16'hFFFF, 1'b0, 16'h0);
    word(16'h00A1); word(16'h00B2); word(16'h00A1); word(16'h00B2); word(16'h00A1);
    chk("ovl1_count", 32'(cnt_a), 32'h5);
    chk("ovl0_count", 32'(cnt_b), 32'h4);
    chk("sat_count",  32'(cnt_c), 32'h3);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg(AW'($urandom_range(0, 3)), pick_word(), 16'hFFFF,
            1'($urandom_range(0, 1)), pick_word());
      end else if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        word(pick_word());
      end
    end

    // Reset mid-sequence
    cfg(2'd0, 16'h00A1, 16'hFFFF, 1'b0, 16'h0);
    cfg(2'd1, 16'h00B2, 16'hFFFF, 1'b0, 16'h0);
    word(16'h00A1);
    rst_n = 1'b0; valid = 1'b1; din = 16'h00B2;
    cycle();
    rst_n = 1'b1;
    chk("rst_out",   32'(out_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'h0);
    chk("rst_busy",  32'(b_a),   32'h0);
    chk("rst_match", 32'(m_a),   32'h0);

`ifdef SEQ_DETECT_MASK_EN
    cfg(2'd0, 16'h00A1, 16'hFF0F, 1'b0, 16'h0);
    cfg(2'd1, 16'h00B2, 16'hFFFF, 1'b0, 16'h0);
    cfg(2'd2, 16'h00C3, 16'hFFFF, 1'b0, 16'h0);
    word(16'h00F1);
    chk("mask_busy", 32'(b_a), 32'h1);
    word(16'h00B2); word(16'h00C3);
    chk("mask_match", 32'(m_a), 32'h1);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg(AW'($urandom_range(0, 3)), pick_word(), 16'($urandom_range(0, 16'hFFFF)),
            1'b0, 16'h0);
      end else begin
        word(pick_word());
      end
    end
`endif

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
